// File: rtl/fibo_bcd_display.sv
// fibo_bcd_display
//   Captures the Fibonacci calculator result when its done flag rises. Converts
//   the binary word to packed BCD with a sequential shift-add-3 (double-dabble)
//   engine, then drives registered active-low 7-segment patterns.
//
//   Optional build macro: LEADING_ZERO_BLANK_EN
//     Defined   : leading zero digits above digit 0 are blanked on the displays.
//     Undefined : every display shows its digit, including leading zeros.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   bin_in     in   WIDTH-bit binary value (calculator fibo_out)
//   done_in    in   calculator done level; its rising edge starts a conversion
//   busy       out  high while a conversion is in progress
//   bcd_valid  out  high when bcd_out/seg_n hold a completed conversion
//   bcd_out    out  packed BCD, digit 0 (ones) at [3:0]
//   seg_n      out  active-low segments, digit k at [7k+6:7k], order {g,f,e,d,c,b,a}
module fibo_bcd_display #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  done_in,
  output logic                  busy,
  output logic                  bcd_valid,
  output logic [DIGITS*4-1:0]   bcd_out,
  output logic [DIGITS*7-1:0]   seg_n
);

  localparam int BCD_W = DIGITS * 4;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               done_q;
  logic               start;
  logic               load;
  logic               publish;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [SR_W-1:0]    sr, sr_nxt;
  logic [BCD_W-1:0]   bcd_new;

  // One double-dabble iteration: correct every BCD nibble that would overflow
  // past 9 when doubled, then shift the whole {bcd, bin} register left by one.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s;
    for (int k = 0; k < DIGITS; k++) begin
      if (t[WIDTH+4*k +: 4] >= 4'd5)
        t[WIDTH+4*k +: 4] = t[WIDTH+4*k +: 4] + 4'd3;
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

  // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles blank the display.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  function automatic logic [DIGITS*7-1:0] seg_word(input logic [BCD_W-1:0] bcd);
    logic [DIGITS*7-1:0] w;
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    lead = 1'b1;
    // Walk from the most significant digit down; blank zeros until the first
    // non-zero digit. Digit 0 is always shown so zero reads as a single "0".
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (lead && (k != 0) && (bcd[4*k +: 4] == 4'd0)) begin
        w[7*k +: 7] = 7'b1111111;
      end else begin
        lead        = 1'b0;
        w[7*k +: 7] = seg7(bcd[4*k +: 4]);
      end
    end
`else
    for (int k = 0; k < DIGITS; k++)
      w[7*k +: 7] = seg7(bcd[4*k +: 4]);
`endif
    return w;
  endfunction

  // Next-state and datapath control. A start is a rising edge of done_in;
  // starts are only honoured outside CONVERT, and done_q keeps tracking the
  // level so a flag held through a conversion never retriggers afterwards.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_nxt    = sr;
    load      = 1'b0;
    publish   = 1'b0;
    start     = done_in & ~done_q;
    case (state)
      IDLE, HOLD: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = CONVERT;
          cnt_nxt   = '0;
          sr_nxt    = {{BCD_W{1'b0}}, bin_in};
        end
      end
      CONVERT: begin
        sr_nxt  = dabble_step(sr);
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          publish   = 1'b1;
          state_nxt = HOLD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bcd_new = sr_nxt[SR_W-1 -: BCD_W];
  assign busy    = (state == CONVERT);

  // Register stage: state, engine and published outputs. bcd_out and seg_n
  // change together, and only when a conversion completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      done_q    <= 1'b0;
      cnt       <= '0;
      sr        <= '0;
      bcd_valid <= 1'b0;
      bcd_out   <= '0;
      seg_n     <= '1;
    end else begin
      state  <= state_nxt;
      done_q <= done_in;
      cnt    <= cnt_nxt;
      sr     <= sr_nxt;
      if (load)
        bcd_valid <= 1'b0;
      if (publish) begin
        bcd_valid <= 1'b1;
        bcd_out   <= bcd_new;
        seg_n     <= seg_word(bcd_new);
      end
    end
  end

endmodule

// File: tb/tb_fibo_bcd_display.sv
module tb_fibo_bcd_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bin_in;
  logic        done_in;
  logic        busy;
  logic        bcd_valid;
  logic [19:0] bcd_out;
  logic [34:0] seg_n;

  int n_chk  = 0;
  int n_fail = 0;

  logic [19:0] exp_q[$];

  fibo_bcd_display #(.WIDTH(16), .DIGITS(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .bin_in    (bin_in),
    .done_in   (done_in),
    .busy      (busy),
    .bcd_valid (bcd_valid),
    .bcd_out   (bcd_out),
    .seg_n     (seg_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Hand-written pattern table for building expected display words.
  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [34:0] seg_exp(input logic [19:0] bcd);
    logic [34:0] w;
    logic        lead;
    lead = 1'b1;
    for (int k = 4; k >= 0; k--) begin
      w[7*k +: 7] = pat(bcd[4*k +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (lead && k != 0 && bcd[4*k +: 4] == 4'd0) w[7*k +: 7] = 7'b1111111;
      else lead = 1'b0;
`endif
    end
    return w;
  endfunction

  // Monitor: on every bcd_valid rise, pop the oldest expected result and check
  // value, display word and number of busy cycles since the capture.
  int   busy_cnt = 0;
  logic vld_prev = 1'b0;
  always @(negedge clk) begin
    logic [19:0] e;
    if (busy) busy_cnt++;
    if (reset) busy_cnt = 0;
    if (!reset && bcd_valid && !vld_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {44'd0, bcd_out}, 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("bcd_out", {44'd0, bcd_out}, {44'd0, e});
        check("seg_n", {29'd0, seg_n}, {29'd0, seg_exp(e)});
        check("busy_cycles", 64'(busy_cnt), 64'd16);
      end
      busy_cnt = 0;
    end
    vld_prev = bcd_valid;
  end

  task automatic start(input logic [15:0] v, input int hold, input bit push, input logic [19:0] e);
    @(posedge clk); #1;
    bin_in  = v;
    done_in = 1'b1;
    if (push) exp_q.push_back(e);
    repeat (hold) @(posedge clk);
    #1 done_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int  n;
    bit  ok;
    ok = 1'b0;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    check({name, "_completes"}, 64'(ok), 64'd1);
  endtask

  initial begin
    reset   = 1'b1;
    bin_in  = '0;
    done_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_valid", 64'(bcd_valid), 64'd0);
    check("rst_bcd",   {44'd0, bcd_out}, 64'h0);
    check("rst_seg",   {29'd0, seg_n}, {29'd0, 35'h7_FFFF_FFFF});

    // Held done level: exactly one conversion.
    start(16'd5, 10, 1'b1, 20'h00005);
    wait_idle("five");
    repeat (20) @(negedge clk);
    check("held_no_retrigger_busy", 64'(busy), 64'd0);
    check("five_seg_d0", 64'(seg_n[6:0]), 64'(7'b0010010));
`ifndef LEADING_ZERO_BLANK_EN
    check("five_seg_d4", 64'(seg_n[34:28]), 64'(7'b1000000));
`else
    check("five_seg_d4", 64'(seg_n[34:28]), 64'(7'b1111111));
`endif

    // Back-to-back conversions; previous result stays visible while converting.
    start(16'd144, 1, 1'b1, 20'h00144);
    wait_idle("f144");
    check("f144_d2", 64'(seg_n[20:14]), 64'(7'b1111001));
    check("f144_d1", 64'(seg_n[13:7]),  64'(7'b0011001));
    check("f144_d0", 64'(seg_n[6:0]),   64'(7'b0011001));
`ifdef LEADING_ZERO_BLANK_EN
    check("f144_d3_blank", 64'(seg_n[27:21]), 64'(7'b1111111));
`else
    check("f144_d3_zero",  64'(seg_n[27:21]), 64'(7'b1000000));
`endif
    start(16'd34, 1, 1'b1, 20'h00034);
    repeat (5) @(negedge clk);
    check("mid_bcd_kept", {44'd0, bcd_out}, 64'h00144);
    check("mid_valid",    64'(bcd_valid), 64'd0);
    check("mid_busy",     64'(busy), 64'd1);
    wait_idle("f34");

    // Boundary values.
    start(16'd65535, 1, 1'b1, 20'h65535);
    wait_idle("max");
    start(16'd0, 1, 1'b1, 20'h00000);
    wait_idle("zero");
    check("zero_d0", 64'(seg_n[6:0]), 64'(7'b1000000));

    // Second rise during CONVERT with a new bin_in is ignored.
    start(16'd377, 1, 1'b1, 20'h00377);
    repeat (4) @(posedge clk);
    #1 bin_in = 16'd610; done_in = 1'b1;
    @(posedge clk);
    #1 done_in = 1'b0;
    wait_idle("ignored_restart");
    repeat (20) @(negedge clk);
    check("no_second_conv", 64'(busy), 64'd0);

    // Reset mid-conversion aborts without publishing.
    start(16'd233, 1, 1'b0, 20'h0);
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy",  64'(busy), 64'd0);
    check("abort_valid", 64'(bcd_valid), 64'd0);
    check("abort_bcd",   {44'd0, bcd_out}, 64'h0);
    check("abort_seg",   {29'd0, seg_n}, {29'd0, 35'h7_FFFF_FFFF});
    repeat (20) @(negedge clk);
    check("abort_stays_blank", {29'd0, seg_n}, {29'd0, 35'h7_FFFF_FFFF});
    start(16'd89, 1, 1'b1, 20'h00089);
    wait_idle("f89");

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
